a23_copro15_ctrl: RTL and testbench

- Parametrised CP15 control block for the Amber 2 core; successor to the fixed-register co-processor.
- Sits beside the execute stage and drives cache enable, cacheable/updateable/disruptive area masks and cache flush.
- Adds a buffered fault-record FIFO, a flush request/acknowledge FSM with stall, and a configurable region count.

---
 rtl/a23_copro_pkg.sv | 26 ++
 rtl/a23_copro_fault_fifo.sv | 58 +++++
 rtl/a23_copro15_ctrl.sv | 164 ++++++++++++++++
 tb/tb_a23_copro15_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/a23_copro_pkg.sv
// Shared definitions for the Amber 2 CP15 control block: register numbers,
// co-processor operation encodings and the flush handshake state type.
package a23_copro_pkg;

  localparam logic [3:0] CRN_ID         = 4'd0;
  localparam logic [3:0] CRN_FLUSH      = 4'd1;
  localparam logic [3:0] CRN_CTRL       = 4'd2;
  localparam logic [3:0] CRN_CACHEABLE  = 4'd3;
  localparam logic [3:0] CRN_UPDATEABLE = 4'd4;
  localparam logic [3:0] CRN_DISRUPTIVE = 4'd5;
  localparam logic [3:0] CRN_FSTATUS    = 4'd6;
  localparam logic [3:0] CRN_FADDR      = 4'd7;
  localparam logic [3:0] CRN_FPOP       = 4'd8;
  localparam logic [3:0] CRN_FOVF       = 4'd9;
  localparam logic [3:0] CRN_FCNT       = 4'd10;

  localparam logic [1:0] OP_MRC = 2'd1;
  localparam logic [1:0] OP_MCR = 2'd2;

  typedef enum logic [1:0] {
    FL_IDLE = 2'd0,
    FL_REQ  = 2'd1,
    FL_WAIT = 2'd2
  } flush_state_e;

endpackage

// File: rtl/a23_copro_fault_fifo.sv
// Fault record FIFO: 40-bit entries {address, status}. A push into a full
// FIFO is dropped and sets a sticky overflow flag; a pop on empty is ignored.
module a23_copro_fault_fifo #(
  parameter int FAULT_DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic [39:0]                  i_push_data,
  input  logic                         i_pop,
  input  logic                         i_ovf_clr,
  output logic [39:0]                  o_head,
  output logic [$clog2(FAULT_DEPTH):0] o_count,
  output logic                         o_empty,
  output logic                         o_overflow
);

  localparam int PW = $clog2(FAULT_DEPTH);
  localparam int CW = PW + 1;

  logic [39:0]   mem_q [FAULT_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          full, pop_ok, push_ok;

  assign full    = (count_q == CW'(FAULT_DEPTH));
  assign o_empty = (count_q == '0);
  assign pop_ok  = i_pop & ~o_empty;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign push_ok = i_push & (~full | pop_ok);

  // Entry storage; not reset, the head is masked while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_push_data;
  end

  // Pointers, occupancy and sticky overflow; a new overflow wins over a clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
      if (i_push && !push_ok) ovf_q <= 1'b1;
      else if (i_ovf_clr)     ovf_q <= 1'b0;
    end
  end

  assign o_head     = o_empty ? 40'd0 : mem_q[rd_ptr_q];
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

endmodule

// File: rtl/a23_copro15_ctrl.sv
// CP15 control block for the Amber 2 core: cache control, area masks,
// buffered fault records and a flush request/acknowledge handshake.
// Optional fault strobe counter at crn 10: define A23_COPRO_FAULT_CNT_EN.
module a23_copro15_ctrl
  import a23_copro_pkg::*;
#(
  parameter int          AREA_BITS   = 32,
  parameter int          FAULT_DEPTH = 4,
  parameter logic [31:0] ID_VALUE    = 32'h4156_0301
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_fetch_stall,
  input  logic [3:0]           i_copro_crn,
  input  logic [1:0]           i_copro_operation,
  input  logic [31:0]          i_copro_write_data,
  input  logic                 i_fault,
  input  logic [7:0]           i_fault_status,
  input  logic [31:0]          i_fault_address,
  input  logic                 i_cache_flush_done,
  output logic [31:0]          o_copro_read_data,
  output logic                 o_copro_stall,
  output logic                 o_cache_enable,
  output logic                 o_cache_flush,
  output logic [AREA_BITS-1:0] o_cacheable_area,
  output logic [AREA_BITS-1:0] o_updateable_area,
  output logic [AREA_BITS-1:0] o_disruptive_area
);

  logic                 wr_en, rd_en, flush_wr;
  logic [2:0]           ctrl_q;
  logic [AREA_BITS-1:0] cacheable_q, updateable_q, disruptive_q;
  logic [31:0]          read_data_q, rd_val;
  flush_state_e         state_q, state_d;
  logic                 pending_q, pending_d;

  logic [39:0]                  fifo_head;
  logic [$clog2(FAULT_DEPTH):0] fifo_count;
  logic                         fifo_empty, fifo_ovf;

  // A stalled fetch freezes every co-processor access.
  assign wr_en    = ~i_fetch_stall & (i_copro_operation == OP_MCR);
  assign rd_en    = ~i_fetch_stall & (i_copro_operation == OP_MRC);
  assign flush_wr = wr_en & (i_copro_crn == CRN_FLUSH);

  // Fault pushes are never gated by the stall so no fault is lost.
  a23_copro_fault_fifo #(.FAULT_DEPTH(FAULT_DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (i_fault),
    .i_push_data ({i_fault_address, i_fault_status}),
    .i_pop       (wr_en & (i_copro_crn == CRN_FPOP)),
    .i_ovf_clr   (wr_en & (i_copro_crn == CRN_FOVF)),
    .o_head      (fifo_head),
    .o_count     (fifo_count),
    .o_empty     (fifo_empty),
    .o_overflow  (fifo_ovf)
  );

`ifdef A23_COPRO_FAULT_CNT_EN
  logic [15:0] fcnt_q;
  // Saturating count of every fault strobe; a clear with a same-cycle fault leaves 1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                  fcnt_q <= '0;
    else if (wr_en && i_copro_crn == CRN_FCNT)  fcnt_q <= {15'd0, i_fault};
    else if (i_fault && fcnt_q != 16'hFFFF)     fcnt_q <= fcnt_q + 16'd1;
  end
`endif

  // Register file read multiplexer, sampled into the read data register.
  always_comb begin
    rd_val = '0;
    case (i_copro_crn)
      CRN_ID:         rd_val = ID_VALUE;
      CRN_CTRL:       rd_val = {29'd0, ctrl_q};
      CRN_CACHEABLE:  rd_val = 32'(cacheable_q);
      CRN_UPDATEABLE: rd_val = 32'(updateable_q);
      CRN_DISRUPTIVE: rd_val = 32'(disruptive_q);
      CRN_FSTATUS:    rd_val = {fifo_ovf, 7'd0, 8'(fifo_count), 8'd0, fifo_head[7:0]};
      CRN_FADDR:      rd_val = fifo_head[39:8];
      CRN_FOVF:       rd_val = {31'd0, fifo_ovf};
`ifdef A23_COPRO_FAULT_CNT_EN
      CRN_FCNT:       rd_val = {16'd0, fcnt_q};
`endif
      default:        rd_val = '0;
    endcase
  end

  // Control registers, area masks and read data capture; writes land even mid-flush.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ctrl_q       <= '0;
      cacheable_q  <= '0;
      updateable_q <= '0;
      disruptive_q <= '0;
      read_data_q  <= '0;
    end else begin
      if (rd_en) read_data_q <= rd_val;
      if (wr_en) begin
        case (i_copro_crn)
          CRN_CTRL:       ctrl_q       <= i_copro_write_data[2:0];
          CRN_CACHEABLE:  cacheable_q  <= i_copro_write_data[AREA_BITS-1:0];
          CRN_UPDATEABLE: updateable_q <= i_copro_write_data[AREA_BITS-1:0];
          CRN_DISRUPTIVE: disruptive_q <= i_copro_write_data[AREA_BITS-1:0];
          default: ;
        endcase
      end
    end
  end

  // Flush handshake state and the single-level pending request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= FL_IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Flush next state: one-cycle request pulse, then stall until the cache acknowledges.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    o_cache_flush = 1'b0;
    o_copro_stall = 1'b0;
    case (state_q)
      FL_IDLE: begin
        if (flush_wr) state_d = FL_REQ;
      end
      FL_REQ: begin
        o_cache_flush = 1'b1;
        o_copro_stall = 1'b1;
        state_d       = FL_WAIT;
        if (flush_wr) pending_d = 1'b1;
      end
      FL_WAIT: begin
        o_copro_stall = 1'b1;
        if (i_cache_flush_done) begin
          if (pending_q || flush_wr) begin
            state_d   = FL_REQ;
            pending_d = 1'b0;
          end else begin
            state_d = FL_IDLE;
          end
        end else if (flush_wr) begin
          pending_d = 1'b1;
        end
      end
      default: begin
        state_d   = FL_IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  assign o_copro_read_data = read_data_q;
  assign o_cache_enable    = ctrl_q[0];
  assign o_cacheable_area  = cacheable_q;
  assign o_updateable_area = updateable_q;
  assign o_disruptive_area = disruptive_q;

endmodule

// File: tb/tb_a23_copro15_ctrl.sv
// Self-checking bench for a23_copro15_ctrl (AREA_BITS=8, FAULT_DEPTH=4).
// Honours A23_COPRO_FAULT_CNT_EN when defined at compile time.
module tb_a23_copro15_ctrl;

  localparam int AB = 8;
  localparam int FD = 4;
  localparam logic [31:0] ID = 32'h4156_0301;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_stall;
  logic [3:0]    crn;
  logic [1:0]    op;
  logic [31:0]   wdata;
  logic          fault;
  logic [7:0]    fstatus;
  logic [31:0]   faddr;
  logic          flush_done;
  logic [31:0]   rdata;
  logic          cstall, cen, cflush;
  logic [AB-1:0] cach, upd, dis;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [2:0]    m_ctrl;
  logic [AB-1:0] m_cach, m_upd, m_dis;
  logic [39:0]   m_q[$];
  logic          m_ovf;
  logic [31:0]   m_rd;
  logic [15:0]   m_fcnt;

  always #5 clk = ~clk;

  a23_copro15_ctrl #(.AREA_BITS(AB), .FAULT_DEPTH(FD), .ID_VALUE(ID)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_fetch_stall      (fetch_stall),
    .i_copro_crn        (crn),
    .i_copro_operation  (op),
    .i_copro_write_data (wdata),
    .i_fault            (fault),
    .i_fault_status     (fstatus),
    .i_fault_address    (faddr),
    .i_cache_flush_done (flush_done),
    .o_copro_read_data  (rdata),
    .o_copro_stall      (cstall),
    .o_cache_enable     (cen),
    .o_cache_flush      (cflush),
    .o_cacheable_area   (cach),
    .o_updateable_area  (upd),
    .o_disruptive_area  (dis)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_cach = '0; m_upd = '0; m_dis = '0;
    m_q.delete(); m_ovf = 1'b0; m_rd = '0; m_fcnt = '0;
  endtask

  function automatic logic [31:0] mread(input logic [3:0] c);
    logic [31:0] v;
    v = 32'd0;
    case (c)
      4'd0: v = ID;
      4'd2: v = {29'd0, m_ctrl};
      4'd3: v = {24'd0, m_cach};
      4'd4: v = {24'd0, m_upd};
      4'd5: v = {24'd0, m_dis};
      4'd6: v = {m_ovf, 7'd0, 8'(m_q.size()), 8'd0, (m_q.size() > 0) ? m_q[0][7:0] : 8'd0};
      4'd7: v = (m_q.size() > 0) ? m_q[0][39:8] : 32'd0;
      4'd9: v = {31'd0, m_ovf};
`ifdef A23_COPRO_FAULT_CNT_EN
      4'd10: v = {16'd0, m_fcnt};
`endif
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  // Apply the architectural effect of the current inputs at the next edge.
  task automatic model_edge();
    logic [31:0] rv;
    logic wr;
    rv = mread(crn);
    wr = !fetch_stall && op == 2'd2;
    if (!fetch_stall && op == 2'd1) m_rd = rv;
    if (wr && crn == 4'd8 && m_q.size() > 0) void'(m_q.pop_front());
    if (wr && crn == 4'd9) m_ovf = 1'b0;
    if (fault) begin
      if (m_q.size() < FD) m_q.push_back({faddr, fstatus});
      else m_ovf = 1'b1;
    end
    if (wr) begin
      case (crn)
        4'd2: m_ctrl = wdata[2:0];
        4'd3: m_cach = wdata[AB-1:0];
        4'd4: m_upd  = wdata[AB-1:0];
        4'd5: m_dis  = wdata[AB-1:0];
        default: ;
      endcase
    end
    if (wr && crn == 4'd10) m_fcnt = fault ? 16'd1 : 16'd0;
    else if (fault && m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 16'd1;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk("read_data", rdata, m_rd);
    chk("cacheable", {24'd0, cach}, {24'd0, m_cach});
    chk("updateable", {24'd0, upd}, {24'd0, m_upd});
    chk("disruptive", {24'd0, dis}, {24'd0, m_dis});
    chk("cache_enable", {31'd0, cen}, {31'd0, m_ctrl[0]});
  endtask

  task automatic idle_in();
    fetch_stall = 0; op = 2'd0; crn = 4'd0; wdata = '0;
    fault = 0; fstatus = '0; faddr = '0; flush_done = 0;
  endtask

  task automatic rd(input logic [3:0] c);
    op = 2'd1; crn = c; cyc(); op = 2'd0;
  endtask

  task automatic wr(input logic [3:0] c, input logic [31:0] d);
    op = 2'd2; crn = c; wdata = d; cyc(); op = 2'd0;
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read_data", rdata, 32'd0);
    chk("rst_masks", {cach, upd, dis}, 32'd0);
    chk("rst_ctl", {29'd0, cstall, cen, cflush}, 32'd0);
    rst = 1'b0;

    // ID read, one cycle latency
    rd(4'd0);
    chk("id_read", rdata, 32'h4156_0301);
    chk("idle_flush_stall", {30'd0, cstall, cflush}, 32'd0);

    // Mask truncated to AREA_BITS, zero-extended on read
    wr(4'd3, 32'hFFFF_FFA5);
    chk("cacheable_a5", {24'd0, cach}, 32'h0000_00A5);
    rd(4'd3);
    chk("cacheable_read", rdata, 32'h0000_00A5);

    // Flush with no pending request
    wr(4'd1, 32'd0);
    chk("flush_req_pulse", {30'd0, cstall, cflush}, 32'd3);
    cyc();
    chk("flush_wait", {30'd0, cstall, cflush}, 32'd2);
    flush_done = 1; cyc(); flush_done = 0;
    chk("flush_done_idle", {30'd0, cstall, cflush}, 32'd0);
    cyc();
    chk("flush_stays_idle", {30'd0, cstall, cflush}, 32'd0);

    // Flush with a second request while waiting, plus a mask write mid-flush
    wr(4'd1, 32'd0);
    chk("flush2_req", {30'd0, cstall, cflush}, 32'd3);
    wr(4'd4, 32'h0000_003C);
    chk("write_mid_flush", {24'd0, upd}, 32'h0000_003C);
    wr(4'd1, 32'd0);
    chk("flush2_wait", {30'd0, cstall, cflush}, 32'd2);
    cyc();
    chk("flush2_still_wait", {30'd0, cstall, cflush}, 32'd2);
    flush_done = 1; cyc(); flush_done = 0;
    chk("pending_req_pulse", {30'd0, cstall, cflush}, 32'd3);
    cyc();
    chk("pending_wait", {30'd0, cstall, cflush}, 32'd2);
    flush_done = 1; cyc(); flush_done = 0;
    chk("pending_done_idle", {30'd0, cstall, cflush}, 32'd0);
    repeat (2) begin
      cyc();
      chk("no_extra_pulse", {30'd0, cstall, cflush}, 32'd0);
    end

    // Five faults into a four-entry FIFO
    for (int i = 0; i < 5; i++) begin
      fault = 1; fstatus = 8'h10 + 8'(i); faddr = 32'(i + 1) * 32'h100;
      cyc();
    end
    fault = 0;
    rd(4'd6);
    chk("fstatus_ovf", rdata, 32'h8004_0010);
    rd(4'd7);
    chk("faddr_head", rdata, 32'h0000_0100);
    wr(4'd8, 32'd0);
    rd(4'd7);
    chk("faddr_after_pop", rdata, 32'h0000_0200);
    wr(4'd9, 32'd0);
    rd(4'd9);
    chk("ovf_cleared", rdata, 32'd0);
    rd(4'd6);
    chk("fstatus_after_pop", rdata, 32'h0003_0011);

    // Stalled ctrl write is lost, fault still queued
    fetch_stall = 1; op = 2'd2; crn = 4'd2; wdata = 32'd7;
    fault = 1; fstatus = 8'h77; faddr = 32'h600;
    cyc();
    fetch_stall = 0; fault = 0; op = 2'd0;
    rd(4'd2);
    chk("ctrl_stall_hold", rdata, 32'd0);
    rd(4'd6);
    chk("fault_during_stall", rdata, 32'h0004_0011);

`ifdef A23_COPRO_FAULT_CNT_EN
    wr(4'd10, 32'd0);
    repeat (3) begin
      fault = 1; faddr = $urandom; fstatus = 8'($urandom); cyc();
    end
    fault = 0;
    rd(4'd10);
    chk("fcnt_three", rdata, 32'd3);
    fault = 1; wr(4'd10, 32'd0); fault = 0;
    rd(4'd10);
    chk("fcnt_clear_and_fault", rdata, 32'd1);
`else
    wr(4'd10, 32'hFFFF_FFFF);
    rd(4'd10);
    chk("fcnt_absent", rdata, 32'd0);
`endif

    // Reset in the middle of a flush with a pending request
    wr(4'd1, 32'd0);
    wr(4'd1, 32'd0);
    #1 rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_mid_flush", {30'd0, cstall, cflush}, 32'd0);
    rst = 1'b0;
    repeat (3) begin
      cyc();
      chk("post_rst_no_flush", {30'd0, cstall, cflush}, 32'd0);
    end

    // Randomised traffic against the model (no flush requests)
    for (int n = 0; n < 600; n++) begin
      fetch_stall = ($urandom_range(0, 4) == 0);
      op          = 2'($urandom_range(0, 3));
      crn         = 4'($urandom_range(0, 11));
      if (op == 2'd2 && crn == 4'd1) crn = 4'd2;
      wdata       = $urandom;
      fault       = ($urandom_range(0, 2) == 0);
      fstatus     = 8'($urandom);
      faddr       = $urandom;
      flush_done  = ($urandom_range(0, 7) == 0);
      cyc();
      chk("rand_no_flush", {30'd0, cstall, cflush}, 32'd0);
    end
    idle_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
